// File: rtl/commit_trace_packer_if.sv
// Commit-port capture bus and serialized trace record stream for commit_trace_packer.
// master = core/consumer side, slave = packer side.
interface commit_trace_packer_if #(
    parameter int RETIRE_WIDTH = 3,
    parameter int ADDR_BITS    = 40,
    parameter int XLEN         = 64
);
    logic                              trace_en;
    logic [RETIRE_WIDTH-1:0]           commit_valid;
    logic [RETIRE_WIDTH*ADDR_BITS-1:0] commit_pc;
    logic [RETIRE_WIDTH*32-1:0]        commit_inst;
    logic [RETIRE_WIDTH*3-1:0]         commit_rtype;
    logic [RETIRE_WIDTH*5-1:0]         commit_ldst;
    logic [RETIRE_WIDTH*XLEN-1:0]      commit_wdata;

    logic                              out_valid;
    logic                              out_ready;
    logic [63:0]                       out_cycle;
    logic [ADDR_BITS-1:0]              out_pc;
    logic [31:0]                       out_inst;
    logic [2:0]                        out_rtype;
    logic [4:0]                        out_ldst;
    logic [XLEN-1:0]                   out_wdata;

    logic                              overflow;
    logic [15:0]                       drop_cnt;

    modport master (
        output trace_en, commit_valid, commit_pc, commit_inst, commit_rtype,
               commit_ldst, commit_wdata, out_ready,
        input  out_valid, out_cycle, out_pc, out_inst, out_rtype, out_ldst,
               out_wdata, overflow, drop_cnt
    );

    modport slave (
        input  trace_en, commit_valid, commit_pc, commit_inst, commit_rtype,
               commit_ldst, commit_wdata, out_ready,
        output out_valid, out_cycle, out_pc, out_inst, out_rtype, out_ldst,
               out_wdata, overflow, drop_cnt
    );
endinterface

// File: rtl/commit_trace_packer.sv
// Retire-event packer: compacts up to RETIRE_WIDTH commits per cycle into a FIFO
// and streams them out one stamped record per cycle; groups that do not fit are dropped whole.

// Per-lane slot allocator: a valid lane lands at wr_ptr plus the number of valid lanes below it.
module commit_trace_lane #(
    parameter int NUM_LANES = 3,
    parameter int LANE      = 0,
    parameter int PTR_W     = 4
) (
    input  logic [NUM_LANES-1:0] valid,
    input  logic [PTR_W-1:0]     wr_ptr,
    output logic                 wr,
    output logic [PTR_W-1:0]     addr
);
    logic [PTR_W-1:0] offset;

    always_comb begin
        offset = '0;
        for (int j = 0; j < LANE; j++) begin
            offset = offset + PTR_W'(valid[j]);
        end
    end

    assign wr   = valid[LANE];
    assign addr = wr_ptr + offset;
endmodule

module commit_trace_packer #(
    parameter int RETIRE_WIDTH = 3,
    parameter int ADDR_BITS    = 40,
    parameter int XLEN         = 64,
    parameter int DEPTH        = 16
) (
    input logic                  clock,
    input logic                  reset,
    commit_trace_packer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int NW    = $clog2(RETIRE_WIDTH + 1);

    typedef struct packed {
        logic [63:0]          cycle;
        logic [ADDR_BITS-1:0] pc;
        logic [31:0]          inst;
        logic [2:0]           rtype;
        logic [4:0]           ldst;
        logic [XLEN-1:0]      wdata;
    } rec_t;

    rec_t                                 mem [DEPTH];
    logic [PTR_W-1:0]                     wr_ptr;
    logic [PTR_W-1:0]                     rd_ptr;
    logic [CNT_W-1:0]                     count;
    logic [63:0]                          cycle_q;
    logic                                 overflow_q;
    logic [15:0]                          drop_cnt_q;

    logic [NW-1:0]                        n_valid;
    logic [CNT_W-1:0]                     free_slots;
    logic                                 grp_any;
    logic                                 accept;
    logic                                 drop;
    logic                                 deq;
    logic [16:0]                          drop_sum;
    logic [CNT_W-1:0]                     enq_amt;

    rec_t [RETIRE_WIDTH-1:0]              lane_rec;
    logic [RETIRE_WIDTH-1:0]              lane_wr;
    logic [RETIRE_WIDTH-1:0][PTR_W-1:0]   lane_addr;
    rec_t                                 head;

    genvar g;
    generate
        for (g = 0; g < RETIRE_WIDTH; g++) begin : g_lane
            assign lane_rec[g] = '{
                cycle: cycle_q,
                pc:    bus.commit_pc[g*ADDR_BITS +: ADDR_BITS],
                inst:  bus.commit_inst[g*32 +: 32],
                rtype: bus.commit_rtype[g*3 +: 3],
                ldst:  bus.commit_ldst[g*5 +: 5],
                wdata: bus.commit_wdata[g*XLEN +: XLEN]
            };

            commit_trace_lane #(
                .NUM_LANES (RETIRE_WIDTH),
                .LANE      (g),
                .PTR_W     (PTR_W)
            ) u_lane (
                .valid  (bus.commit_valid),
                .wr_ptr (wr_ptr),
                .wr     (lane_wr[g]),
                .addr   (lane_addr[g])
            );
        end
    endgenerate

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            n_valid = n_valid + NW'(bus.commit_valid[i]);
        end
    end

    // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
    assign free_slots = CNT_W'(DEPTH) - count;
    assign grp_any    = bus.trace_en && (n_valid != '0);
    assign accept     = grp_any && (CNT_W'(n_valid) <= free_slots);
    assign drop       = grp_any && !accept;
    assign deq        = (count != '0) && bus.out_ready;
    assign drop_sum   = {1'b0, drop_cnt_q} + 17'(n_valid);
    assign enq_amt    = accept ? CNT_W'(n_valid) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            // Clearing storage keeps the don't-care head fields free of X.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (accept) begin
                for (int i = 0; i < RETIRE_WIDTH; i++) begin
                    if (lane_wr[i]) begin
                        mem[lane_addr[i]] <= lane_rec[i];
                    end
                end
                wr_ptr <= wr_ptr + PTR_W'(n_valid);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + enq_amt - CNT_W'(deq);
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    assign head = mem[rd_ptr];

    assign bus.out_valid = (count != '0);
    assign bus.out_cycle = head.cycle;
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;
    assign bus.out_rtype = head.rtype;
    assign bus.out_ldst  = head.ldst;
    assign bus.out_wdata = head.wdata;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_commit_trace_packer.sv
// Directed + randomized bench for commit_trace_packer against a queue-based reference model.
module tb_commit_trace_packer;
    localparam int RW    = 3;
    localparam int AB    = 40;
    localparam int XL    = 64;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [63:0]   cycle;
        logic [AB-1:0] pc;
        logic [31:0]   inst;
        logic [2:0]    rtype;
        logic [4:0]    ldst;
        logic [XL-1:0] wdata;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    commit_trace_packer_if #(.RETIRE_WIDTH(RW), .ADDR_BITS(AB), .XLEN(XL)) bus ();

    commit_trace_packer #(
        .RETIRE_WIDTH (RW),
        .ADDR_BITS    (AB),
        .XLEN         (XL),
        .DEPTH        (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int              checks = 0;
    int              errors = 0;
    rec_t            q[$];
    longint unsigned m_cycle = 0;
    int              m_drop = 0;
    bit              m_ovf = 1'b0;
    int              pushed;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        rec_t obs;
        obs = '{bus.out_cycle, bus.out_pc, bus.out_inst, bus.out_rtype, bus.out_ldst, bus.out_wdata};
        chk("out_valid", 256'(bus.out_valid), 256'(q.size() != 0));
        chk("drop_cnt", 256'(bus.drop_cnt), 256'(m_drop));
        chk("overflow", 256'(bus.overflow), 256'(m_ovf));
        if (q.size() != 0) chk("head_record", 256'(obs), 256'(q[0]));
        else               chk("idle_fields_known", 256'($isunknown(obs)), 256'(0));
    endtask

    // Reference behaviour for one clock edge, from the current inputs.
    task automatic model_update();
        int old;
        int n;
        rec_t r;
        if (reset) begin
            q.delete();
            m_cycle = 0;
            m_drop  = 0;
            m_ovf   = 1'b0;
            return;
        end
        old = q.size();
        n = 0;
        for (int i = 0; i < RW; i++) n += int'(bus.commit_valid[i]);
        if (bus.trace_en && n > 0) begin
            if (n <= DEPTH - old) begin
                for (int i = 0; i < RW; i++) begin
                    if (bus.commit_valid[i]) begin
                        r.cycle = m_cycle;
                        r.pc    = bus.commit_pc[i*AB +: AB];
                        r.inst  = bus.commit_inst[i*32 +: 32];
                        r.rtype = bus.commit_rtype[i*3 +: 3];
                        r.ldst  = bus.commit_ldst[i*5 +: 5];
                        r.wdata = bus.commit_wdata[i*XL +: XL];
                        q.push_back(r);
                        pushed++;
                    end
                end
            end else begin
                m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
                m_ovf  = 1'b1;
            end
        end
        if (old > 0 && bus.out_ready) void'(q.pop_front());
        m_cycle++;
    endtask

    task automatic step();
        check_outputs();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_group(logic [RW-1:0] mask);
        bus.commit_valid = mask;
        for (int i = 0; i < RW; i++) begin
            bus.commit_pc[i*AB +: AB]    = AB'({$urandom(), $urandom()});
            bus.commit_inst[i*32 +: 32]  = $urandom();
            bus.commit_rtype[i*3 +: 3]   = 3'($urandom_range(7));
            bus.commit_ldst[i*5 +: 5]    = 5'($urandom_range(31));
            bus.commit_wdata[i*XL +: XL] = {$urandom(), $urandom()};
        end
    endtask

    initial begin
        logic [AB-1:0] pc_a;
        logic [AB-1:0] pc_c;
        int            guard;

        pushed        = 0;
        bus.trace_en  = 1'b1;
        bus.out_ready = 1'b0;
        drive_group('0);
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        model_update();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_drop_cnt", 256'(bus.drop_cnt), 256'(0));
        chk("rst_overflow", 256'(bus.overflow), 256'(0));

        // Single retire at stamp 5
        bus.out_ready = 1'b1;
        while (m_cycle < 5) step();
        drive_group(3'b001);
        bus.commit_pc[0 +: AB]    = 40'h0080000000;
        bus.commit_inst[0 +: 32]  = 32'h00100093;
        bus.commit_rtype[0 +: 3]  = 3'd0;
        bus.commit_ldst[0 +: 5]   = 5'd1;
        bus.commit_wdata[0 +: XL] = 64'd1;
        step();
        drive_group('0);
        chk("single_valid", 256'(bus.out_valid), 256'(1));
        chk("single_cycle", 256'(bus.out_cycle), 256'(5));
        chk("single_pc", 256'(bus.out_pc), 256'(40'h0080000000));
        chk("single_inst", 256'(bus.out_inst), 256'(32'h00100093));
        step();
        chk("single_gone", 256'(bus.out_valid), 256'(0));

        // Compaction across a hole at port 1
        drive_group(3'b101);
        pc_a = bus.commit_pc[0 +: AB];
        pc_c = bus.commit_pc[2*AB +: AB];
        step();
        drive_group('0);
        chk("compact_first", 256'(bus.out_pc), 256'(pc_a));
        step();
        chk("compact_second", 256'(bus.out_pc), 256'(pc_c));
        chk("compact_same_stamp", 256'(bus.out_cycle), 256'(m_cycle - 2));
        step();
        chk("compact_done", 256'(bus.out_valid), 256'(0));

        // Backpressure to full, atomic drop, then exact fill
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin drive_group(3'b111); step(); end
        drive_group(3'b111); step();
        chk("full_drop_cnt", 256'(bus.drop_cnt), 256'(3));
        chk("full_overflow", 256'(bus.overflow), 256'(1));
        drive_group(3'b010); step();
        chk("full_drop_hold", 256'(bus.drop_cnt), 256'(3));
        // Full with a pop in the same cycle still drops
        bus.out_ready = 1'b1;
        drive_group(3'b100); step();
        chk("conservative_drop", 256'(bus.drop_cnt), 256'(4));
        drive_group('0);
        for (int k = 0; k < 15; k++) step();
        chk("drained_after_16", 256'(bus.out_valid), 256'(0));

        // Wrap-around ordering under random backpressure
        pushed = 0;
        guard  = 0;
        while (pushed < 40 && guard < 400) begin
            bus.out_ready = 1'($urandom_range(1));
            if (q.size() + RW < DEPTH) drive_group(RW'($urandom()));
            else                      drive_group('0);
            step();
            guard++;
        end
        chk("wrap_streamed_40", 256'(pushed >= 40), 256'(1));
        chk("wrap_no_new_drops", 256'(bus.drop_cnt), 256'(4));
        drive_group('0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) step();

        // Reset mid-operation with 7 records queued
        bus.out_ready = 1'b0;
        drive_group(3'b111); step();
        drive_group(3'b111); step();
        drive_group(3'b001); step();
        chk("queued_seven", 256'(q.size()), 256'(7));
        drive_group(3'b111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_group('0);
        chk("midrst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("midrst_drop_cnt", 256'(bus.drop_cnt), 256'(0));
        chk("midrst_overflow", 256'(bus.overflow), 256'(0));
        drive_group(3'b010); step();
        chk("midrst_stamp0", 256'(bus.out_cycle), 256'(0));
        drive_group('0);
        bus.out_ready = 1'b1;
        step();

        // Capture disabled: nothing queued, nothing counted
        bus.trace_en = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin drive_group(3'b111); step(); end
        chk("disabled_no_rec", 256'(bus.out_valid), 256'(0));
        chk("disabled_no_drop", 256'(bus.drop_cnt), 256'(0));
        bus.trace_en = 1'b1;

        // Random mix including occasional resets
        for (int k = 0; k < 400; k++) begin
            bus.trace_en  = ($urandom_range(9) != 0);
            bus.out_ready = 1'($urandom_range(1));
            reset         = ($urandom_range(60) == 0);
            drive_group(RW'($urandom()));
            step();
        end
        reset = 1'b0;

        // drop_cnt saturation
        reset = 1'b1; drive_group('0); step(); reset = 1'b0;
        bus.trace_en  = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin drive_group(3'b111); step(); end
        for (int k = 0; k < 21860; k++) begin drive_group(3'b111); step(); end
        chk("drop_saturated", 256'(bus.drop_cnt), 256'(16'hFFFF));
        drive_group(3'b111); step();
        chk("drop_stays_sat", 256'(bus.drop_cnt), 256'(16'hFFFF));
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
